// File: rtl/relu_quantize.sv
// Serial ReLU + arithmetic-shift rescale + unsigned saturation over a vector of signed node sums.
// Latency: result vector valid NODES cycles after the capture edge; one node per cycle through a shared datapath.
// Backpressure: holds actOut/satFlags/actValid indefinitely until actReady; inReady low outside IDLE.
module relu_quantize #(
  parameter int NODES     = 4,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT     = 4
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic [NODES*IN_WIDTH-1:0]    sumIn,
  input  logic                         sumValid,
  output logic                         inReady,
  output logic [NODES*OUT_WIDTH-1:0]   actOut,
  output logic [NODES-1:0]             satFlags,
  output logic                         actValid,
  input  logic                         actReady
);

  localparam int IDX_W = (NODES > 1) ? $clog2(NODES) : 1;
  // One bit wider than either operand so the saturation compare never wraps.
  localparam int CMP_W = ((IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NODES - 1);
  localparam logic [CMP_W-1:0] ACT_MAX  = CMP_W'({OUT_WIDTH{1'b1}});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    HOLD = 2'd2
  } stateT;

  stateT                      state;
  stateT                      stateNext;
  logic [IDX_W-1:0]           idx;
  logic [NODES*IN_WIDTH-1:0]  sumReg;

  logic signed [IN_WIDTH-1:0] curSum;
  logic signed [IN_WIDTH-1:0] shifted;
  logic [CMP_W-1:0]           shiftedWide;
  logic [OUT_WIDTH-1:0]       nodeAct;
  logic                       nodeSat;

  assign inReady = (state == IDLE) && !clr;

  // State register; clr returns to IDLE from anywhere, abandoning a partial vector.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic: capture in IDLE, walk nodes in PROC, wait for the consumer in HOLD.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (sumValid) stateNext = PROC;
      PROC: if (idx == LAST_IDX) stateNext = HOLD;
      HOLD: if (actValid && actReady) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Shared per-node datapath: negative sums clamp to zero, others shift then saturate.
  always_comb begin
    curSum      = sumReg[idx*IN_WIDTH +: IN_WIDTH];
    shifted     = curSum >>> SHIFT;
    shiftedWide = CMP_W'($unsigned(shifted));
    nodeAct     = '0;
    nodeSat     = 1'b0;
    if (!curSum[IN_WIDTH-1]) begin
      if (shiftedWide > ACT_MAX) begin
        nodeAct = '1;
        nodeSat = 1'b1;
      end else begin
        nodeAct = shiftedWide[OUT_WIDTH-1:0];
      end
    end
  end

  // Capture register, node index and registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      sumReg   <= '0;
      idx      <= '0;
      actOut   <= '0;
      satFlags <= '0;
      actValid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sumValid) begin
            sumReg <= sumIn;
            idx    <= '0;
          end
        end
        PROC: begin
          actOut[idx*OUT_WIDTH +: OUT_WIDTH] <= nodeAct;
          satFlags[idx]                      <= nodeSat;
          if (idx == LAST_IDX) begin
            idx      <= '0;
            actValid <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        HOLD: begin
          if (actValid && actReady) actValid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
